spi_adc_scanner: RTL and testbench
==================================

Name: spi_adc_scanner

Overview:
Parametrised SPI master that continuously scans a multi-channel SAR ADC. It generates SCLK, nCS and the command bitstream (DOUT), and shifts in the conversion result from DIN. It runs a round-robin over a channel enable mask and presents each result with a one-cycle valid strobe. It sits between the ADC pins and the downstream sample consumer, for example the Pi-facing SPI slave or the LED display logic, and replaces the fixed single-channel ADC reader.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period (>=2)
NUM_CH, 2, number of ADC channels (>=2)
DATA_W, 10, result bits per conversion
NULL_BITS, 1, dead SCLK cycles between the address and the data phase
GAP_CYC, 8, minimum clk cycles nCS stays high between frames

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  scanning enable
ch_mask  in  NUM_CH  per-channel enable; bit i=1 includes channel i
din  in  1  serial data from ADC (MISO)
sclk  out  1  SPI clock, idle low
dout  out  1  command bits to ADC (MOSI)
ncs  out  1  ADC chip select, active low
sample  out  DATA_W  last completed result
sample_ch  out  CH_W  channel of sample; CH_W=$clog2(NUM_CH)
sample_valid  out  1  one-cycle strobe, sample/sample_ch updated
busy  out  1  high from nCS fall through the end of GAP

Behaviour:
- Reset (async, active-high): ncs=1, sclk=0, dout=0, sample=0, sample_ch=0, sample_valid=0, busy=0, channel pointer=NUM_CH-1 so the first selected channel is 0. Reset mid-frame aborts the frame immediately. No valid is produced for the aborted frame.
- Frame: FRAME_BITS = 1 + CH_W + NULL_BITS + DATA_W SCLK periods. Command bits are a start bit (1), then the address MSB first, then zeros. The null and data phases drive dout=0.
- SPI mode 0: dout changes on the falling SCLK edge, or at nCS fall for the first bit. din is sampled on the rising SCLK edge. Only the last DATA_W rising edges shift into the result, MSB first.
- FSM IDLE -> SETUP -> SHIFT -> DONE -> GAP -> IDLE.
- IDLE: if en=1 and ch_mask!=0, select the next enabled channel after the pointer, wrapping modulo NUM_CH. Then go to SETUP. Otherwise stay in IDLE with outputs idle.
- SETUP: ncs=0, dout=start bit, sclk=0 for CLK_DIV cycles.
- SHIFT: sclk toggles every CLK_DIV cycles. The state ends after the falling edge that follows the FRAME_BITS-th rising edge.
- DONE (1 cycle): ncs=1, sclk=0, dout=0, sample_valid=1, sample and sample_ch loaded.
- GAP: ncs=1 for GAP_CYC cycles, then IDLE.
- Timing: nCS is low for CLK_DIV*(2*FRAME_BITS+1) clk cycles. sample_valid is asserted in the first ncs-high cycle.
- en deasserted mid-frame: the frame completes with valid, then the block stays in IDLE.
- ch_mask changes: sampled only in IDLE. A change mid-frame affects the next selection only.
- Single enabled channel: the same channel is converted repeatedly.
- sample holds its value between valids.

Optional Feature:
SPI_ADC_OVERSAMPLE_EN
- Defined: each selected channel is converted 4 times back-to-back, each frame with its normal GAP. Results are summed in a DATA_W+2 accumulator. One sample_valid is issued per 4 frames, with sample = sum>>2 (floor). Reset or en=0 between sub-frames discards the partial sum and produces no valid.
- Undefined: one frame per valid, as above. No accumulator is present.

Test Plan:
(All scenarios use defaults: FRAME_BITS=13, nCS low for 108 cycles.)
1. mask=2'b01, en=1, ADC model returns 10'h2A5 -> dout sequence 1,0,0 then zeros. sample=10'h2A5, sample_ch=0, sample_valid high for exactly 1 cycle. nCS low for 108 cycles, then high for >=8 cycles.
2. mask=2'b11, model returns 10'h100 on ch0 and 10'h0FF on ch1 -> valids in order ch0,ch1,ch0 with the matching values. Address bit on dout alternates 0,1,0.
3. mask=2'b00, en=1 for 500 cycles -> ncs=1, sclk=0, busy=0, no sample_valid.
4. Reset asserted 50 cycles into a frame -> ncs=1 and sclk=0 without waiting for clk, no valid. After release, the first frame addresses ch0.
5. din held at 1; en dropped 40 cycles into a frame -> the frame finishes with sample=10'h3FF, after which ncs stays high and no further frames start.
6. With SPI_ADC_OVERSAMPLE_EN, model returns 100,101,102,103 on ch0 -> one valid after 4 frames, sample=101.

Source files
------------

// File: rtl/spi_adc_scanner.sv
// spi_adc_scanner: SPI mode-0 master that round-robins a multi-channel SAR ADC
// over an enable mask and presents each conversion with a one-cycle strobe.
// Optional build macro: SPI_ADC_OVERSAMPLE_EN (average 4 frames per result).
module spi_adc_scanner #(
  parameter int CLK_DIV   = 4,
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 10,
  parameter int NULL_BITS = 1,
  parameter int GAP_CYC   = 8,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              din,
  output logic              sclk,
  output logic              dout,
  output logic              ncs,
  output logic [DATA_W-1:0] sample,
  output logic [CH_W-1:0]   sample_ch,
  output logic              sample_valid,
  output logic              busy
);

  localparam int FRAME_BITS = 1 + CH_W + NULL_BITS + DATA_W;
  localparam int CNT_MAX    = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int RISE_W     = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_DONE, S_GAP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;      // clk cycles within an SCLK half or the gap
  logic                  sclk_q;     // SCLK level while shifting
  logic [RISE_W-1:0]     rise_q;     // SCLK rising edges issued this frame
  logic [FRAME_BITS-1:0] cmd_q;      // command word, MSB drives dout
  logic [DATA_W-1:0]     rx_q;       // last DATA_W bits seen on din
  logic [CH_W-1:0]       ptr_q;      // last channel selected
  logic [CH_W-1:0]       cur_ch_q;   // channel of the frame in flight
  logic [CH_W-1:0]       hi_ch, lo_ch, pick_ch, start_ch;
  logic                  found_hi, start, half_end, frame_end;

`ifdef SPI_ADC_OVERSAMPLE_EN
  logic [1:0]            os_cnt_q;   // sub-frames completed in the current group
  logic [DATA_W+1:0]     acc_q;
  logic [DATA_W+1:0]     sum;

  assign sum      = acc_q + {2'b00, rx_q};
  // A group in progress keeps its channel and ignores the mask until it closes.
  assign start    = en && ((os_cnt_q != 2'd0) || (|ch_mask));
  assign start_ch = (os_cnt_q != 2'd0) ? cur_ch_q : pick_ch;
`else
  assign start    = en && (|ch_mask);
  assign start_ch = pick_ch;
`endif

  assign half_end  = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign frame_end = half_end && !sclk_q && (rise_q == RISE_W'(FRAME_BITS));

  // Next enabled channel after the pointer: lowest above it, else lowest overall.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    found_hi = 1'b0;
    hi_ch    = '0;
    lo_ch    = '0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (ch_mask[j]) begin
        if (CH_W'(j) > ptr_q) begin
          found_hi = 1'b1;
          hi_ch    = CH_W'(j);
        end else begin
          lo_ch = CH_W'(j);
        end
      end
    end
    pick_ch = found_hi ? hi_ch : lo_ch;
  end

  // Next-state and pin decode; pins are pure functions of registered state.
  always_comb begin
    state_d      = state_q;
    ncs          = 1'b1;
    sclk         = 1'b0;
    dout         = 1'b0;
    sample_valid = 1'b0;
    busy         = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  if (start) state_d = S_SETUP;
      S_SETUP: begin
        ncs  = 1'b0;
        dout = cmd_q[FRAME_BITS-1];
        if (half_end) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        ncs  = 1'b0;
        sclk = sclk_q;
        dout = cmd_q[FRAME_BITS-1];
        if (frame_end) state_d = S_DONE;
      end
      S_DONE: begin
`ifdef SPI_ADC_OVERSAMPLE_EN
        sample_valid = (os_cnt_q == 2'd0);  // counter wrapped on the 4th frame
`else
        sample_valid = 1'b1;
`endif
        state_d = S_GAP;
      end
      S_GAP:   if (cnt_q == CNT_W'(GAP_CYC - 1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; async reset aborts any frame and raises nCS at once.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath: SCLK divider, command shifter, receive shifter and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      sclk_q    <= 1'b0;
      rise_q    <= '0;
      cmd_q     <= '0;
      rx_q      <= '0;
      ptr_q     <= CH_W'(NUM_CH - 1);
      cur_ch_q  <= '0;
      sample    <= '0;
      sample_ch <= '0;
`ifdef SPI_ADC_OVERSAMPLE_EN
      os_cnt_q  <= '0;
      acc_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q  <= '0;
          sclk_q <= 1'b0;
          rise_q <= '0;
          if (start) begin
            ptr_q    <= start_ch;
            cur_ch_q <= start_ch;
            cmd_q    <= FRAME_BITS'({1'b1, start_ch}) << (NULL_BITS + DATA_W);
          end
`ifdef SPI_ADC_OVERSAMPLE_EN
          if (!en) begin
            os_cnt_q <= '0;
            acc_q    <= '0;
          end
`endif
        end
        S_SETUP, S_SHIFT: begin
          if (half_end) begin
            cnt_q <= '0;
            if (sclk_q) begin
              // Falling edge: present the next command bit.
              sclk_q <= 1'b0;
              cmd_q  <= cmd_q << 1;
            end else if (!frame_end) begin
              // Rising edge: sample din; only the last DATA_W survive.
              sclk_q <= 1'b1;
              rise_q <= rise_q + 1'b1;
              rx_q   <= {rx_q[DATA_W-2:0], din};
            end else begin
`ifdef SPI_ADC_OVERSAMPLE_EN
              os_cnt_q <= os_cnt_q + 1'b1;
              if (os_cnt_q == 2'd3) begin
                sample    <= sum[DATA_W+1:2];
                sample_ch <= cur_ch_q;
                acc_q     <= '0;
              end else begin
                acc_q <= sum;
              end
`else
              sample    <= rx_q;
              sample_ch <= cur_ch_q;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == CNT_W'(GAP_CYC - 1)) cnt_q <= '0;
          else                              cnt_q <= cnt_q + 1'b1;
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_scanner.sv
// tb_spi_adc_scanner: randomized bench with a behavioural ADC and a
// round-robin scan model; compares frames and results against the DUT.
module tb_spi_adc_scanner;

  localparam int CLK_DIV    = 4;
  localparam int NUM_CH     = 2;
  localparam int DATA_W     = 10;
  localparam int NULL_BITS  = 1;
  localparam int GAP_CYC    = 8;
  localparam int CH_W       = $clog2(NUM_CH);
  localparam int FRAME_BITS = 1 + CH_W + NULL_BITS + DATA_W;
  localparam int DATA_START = 1 + CH_W + NULL_BITS;
  localparam int LOW_CYC    = CLK_DIV * (2 * FRAME_BITS + 1);
`ifdef SPI_ADC_OVERSAMPLE_EN
  localparam int FRAMES_PER_VALID = 4;
`else
  localparam int FRAMES_PER_VALID = 1;
`endif
  localparam int BUDGET = 1000 * FRAMES_PER_VALID;

  logic              clk = 1'b0;
  logic              reset, en, din_one;
  logic [NUM_CH-1:0] ch_mask;
  logic              din = 1'b0;
  logic              sclk, dout, ncs, sample_valid, busy;
  logic [DATA_W-1:0] sample;
  logic [CH_W-1:0]   sample_ch;

  spi_adc_scanner #(
    .CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH), .DATA_W(DATA_W),
    .NULL_BITS(NULL_BITS), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .ch_mask(ch_mask), .din(din),
    .sclk(sclk), .dout(dout), .ncs(ncs), .sample(sample),
    .sample_ch(sample_ch), .sample_valid(sample_valid), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct { int cmd; int low; int gap; } frame_t;
  typedef struct { int ch; int data; } valid_t;

  frame_t frame_q[$];
  valid_t valid_q[$];
  int     os_vals[$];
  int     adc_val[NUM_CH];
  int     os_rd = 0, timing_bad = 0, idle_viol = 0, n_falls = 0;
  int     rd_v = 0, rd_f = 0, exp_ptr = NUM_CH - 1;
  int     vectors = 0, miscompares = 0;

  // ADC model and pin monitor, sampled mid-cycle on the falling clk edge.
  logic prev_ncs = 1'b1, prev_sclk = 1'b0, prev_valid = 1'b0;
  int   low_cnt = 0, high_cnt = 0, rises = 0, falls = 0, cmd = 0, word = 0, gap_before = 0;
  always @(negedge clk) begin
    if (reset) begin
      din      = 1'b0;
      high_cnt = 0;
    end else begin
      if (!ncs && prev_ncs) begin
        gap_before = high_cnt;
        low_cnt = 0; rises = 0; falls = 0; cmd = 0; din = 1'b0;
        n_falls++;
      end
      if (!ncs) begin
        low_cnt++;
        if (sclk && !prev_sclk) begin
          cmd = (cmd << 1) | int'(dout);
          rises++;
        end
        if (!sclk && prev_sclk) begin
          falls++;
          if (falls == DATA_START) begin
            int addr;
            addr = (cmd >> NULL_BITS) & ((1 << CH_W) - 1);
            if (os_rd < os_vals.size()) begin
              word = os_vals[os_rd];
              os_rd++;
            end else if (addr < NUM_CH) word = adc_val[addr];
            else word = 0;
          end
          if (falls >= DATA_START && falls < FRAME_BITS)
            din = ((word >> (DATA_W - 1 - (falls - DATA_START))) & 1) != 0;
        end
      end else begin
        if (!prev_ncs) begin
          frame_q.push_back('{cmd, low_cnt, gap_before});
          high_cnt = 0;
        end
        high_cnt++;
      end
`ifdef SPI_ADC_OVERSAMPLE_EN
      if (sample_valid && !(ncs && !prev_ncs)) timing_bad++;
`else
      if ((ncs && !prev_ncs) != sample_valid) timing_bad++;
`endif
      if (sample_valid && prev_valid) timing_bad++;
      if (!ncs || sclk || busy || sample_valid) idle_viol++;
      if (sample_valid) valid_q.push_back('{int'(sample_ch), int'(sample)});
      if (din_one) din = 1'b1;
    end
    prev_ncs   = ncs;
    prev_sclk  = sclk;
    prev_valid = sample_valid;
  end

  // Round-robin reference: first enabled channel after ptr, wrapping.
  function automatic int rr_next(input int ptr, input int mask);
    for (int off = 1; off <= NUM_CH; off++) begin
      int c;
      c = (ptr + off) % NUM_CH;
      if (((mask >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  function automatic int exp_cmd(input int ch);
    return ((1 << CH_W) | ch) << (NULL_BITS + DATA_W);
  endfunction

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; ch_mask = '0; din_one = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    rd_v = valid_q.size();
    rd_f = frame_q.size();
    exp_ptr = NUM_CH - 1;
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (n < BUDGET && rd_v >= valid_q.size()) begin
      @(negedge clk); #1; n++;
    end
    ok = (rd_v < valid_q.size());
  endtask

  task automatic wait_ncs_low(output bit ok);
    int n;
    n = 0;
    while (n < BUDGET && ncs !== 1'b0) begin
      @(negedge clk); #1; n++;
    end
    ok = (ncs === 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    vectors++; if (ncs !== 1'b1) begin miscompares++; $display("FAIL reset_ncs: got %b expected 1", ncs); end
    vectors++; if (sclk !== 1'b0) begin miscompares++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    vectors++; if (dout !== 1'b0) begin miscompares++; $display("FAIL reset_dout: got %b expected 0", dout); end
    vectors++; if (sample !== '0) begin miscompares++; $display("FAIL reset_sample: got %h expected 0", sample); end
    vectors++; if (sample_ch !== '0) begin miscompares++; $display("FAIL reset_sample_ch: got %h expected 0", sample_ch); end
    vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", sample_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    do_reset();
    repeat (5) @(negedge clk);
    #1;
    vectors++; if (ncs !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL idle_en0: got ncs=%b busy=%b expected ncs=1 busy=0", ncs, busy);
    end
  endtask

  // Scan scenario: predicts channel order, result, command word and frame timing.
  task automatic test_scan(input string name, input int mask, input int nvalid, input bit shuffle);
    int exp_ch, exp_val, nfr, tb0;
    bit ok;
    valid_t v;
    frame_t f;
    do_reset();
    ch_mask = NUM_CH'(mask);
    tb0 = timing_bad;
    en = 1'b1;
    for (int k = 0; k < nvalid; k++) begin
      exp_ch  = rr_next(exp_ptr, mask);
      exp_ptr = exp_ch;
      exp_val = adc_val[exp_ch];
      wait_valid(ok);
      vectors++;
      if (!ok) begin
        miscompares++; $display("FAIL %s_timeout: got no valid in %0d cycles, expected one", name, BUDGET);
        break;
      end
      v = valid_q[rd_v]; rd_v++;
      vectors++; if (v.ch != exp_ch) begin miscompares++; $display("FAIL %s_ch[%0d]: got %0d expected %0d", name, k, v.ch, exp_ch); end
      vectors++; if (v.data != exp_val) begin miscompares++; $display("FAIL %s_data[%0d]: got %0h expected %0h", name, k, v.data, exp_val); end
      nfr = 0;
      while (rd_f < frame_q.size()) begin
        f = frame_q[rd_f]; rd_f++;
        vectors++; if (f.cmd != exp_cmd(exp_ch)) begin miscompares++; $display("FAIL %s_cmd[%0d]: got %0h expected %0h", name, k, f.cmd, exp_cmd(exp_ch)); end
        vectors++; if (f.low != LOW_CYC) begin miscompares++; $display("FAIL %s_ncs_low[%0d]: got %0d expected %0d", name, k, f.low, LOW_CYC); end
        if (k > 0 || nfr > 0) begin
          vectors++; if (f.gap < GAP_CYC) begin miscompares++; $display("FAIL %s_gap[%0d]: got %0d expected >=%0d", name, k, f.gap, GAP_CYC); end
        end
        nfr++;
      end
      vectors++; if (nfr != FRAMES_PER_VALID) begin miscompares++; $display("FAIL %s_frames[%0d]: got %0d expected %0d", name, k, nfr, FRAMES_PER_VALID); end
      if (shuffle) begin
        mask = $urandom_range(1, (1 << NUM_CH) - 1);
        ch_mask = NUM_CH'(mask);
        for (int c = 0; c < NUM_CH; c++) adc_val[c] = $urandom_range(0, (1 << DATA_W) - 1);
      end
    end
    en = 1'b0;
    vectors++; if (timing_bad != tb0) begin miscompares++; $display("FAIL %s_strobe: got %0d strobe faults expected 0", name, timing_bad - tb0); end
  endtask

  task automatic test_mask_zero();
    int iv0, v0;
    do_reset();
    iv0 = idle_viol; v0 = valid_q.size();
    en = 1'b1;
    repeat (500) @(negedge clk);
    #1;
    vectors++; if (idle_viol != iv0) begin miscompares++; $display("FAIL mask0_idle: got %0d active cycles expected 0", idle_viol - iv0); end
    vectors++; if (valid_q.size() != v0) begin miscompares++; $display("FAIL mask0_valid: got %0d valids expected 0", valid_q.size() - v0); end
    en = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int v0;
    valid_t v;
    frame_t f;
    do_reset();
    ch_mask = 2'b11; en = 1'b1;
    wait_ncs_low(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_start: got no frame expected one"); end
    repeat (50) @(negedge clk);
    v0 = valid_q.size();
    #1 reset = 1'b1;
    #1;
    vectors++; if (ncs !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_async: got ncs=%b sclk=%b busy=%b expected 1,0,0", ncs, sclk, busy);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++; if (valid_q.size() != v0) begin miscompares++; $display("FAIL rstmid_valid: got %0d valids expected 0", valid_q.size() - v0); end
    rd_v = valid_q.size(); rd_f = frame_q.size();
    wait_valid(ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL rstmid_timeout: got no valid expected one");
    end else begin
      v = valid_q[rd_v]; rd_v++;
      f = frame_q[rd_f];
      rd_f = frame_q.size();
      vectors++; if (v.ch != 0 || v.data != adc_val[0]) begin
        miscompares++; $display("FAIL rstmid_first: got ch%0d=%0h expected ch0=%0h", v.ch, v.data, adc_val[0]);
      end
      vectors++; if (f.cmd != exp_cmd(0)) begin miscompares++; $display("FAIL rstmid_cmd: got %0h expected %0h", f.cmd, exp_cmd(0)); end
    end
    en = 1'b0;
  endtask

  task automatic test_en_drop();
    bit ok;
    int n0, v0;
    valid_t v;
    do_reset();
    ch_mask = 2'b01; din_one = 1'b1; en = 1'b1;
    wait_ncs_low(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL endrop_start: got no frame expected one"); end
    repeat (40) @(negedge clk);
    en = 1'b0;
`ifdef SPI_ADC_OVERSAMPLE_EN
    v0 = valid_q.size();
    repeat (300) @(negedge clk);
    #1;
    vectors++; if (valid_q.size() != v0) begin miscompares++; $display("FAIL endrop_partial: got %0d valids expected 0", valid_q.size() - v0); end
`else
    wait_valid(ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL endrop_timeout: got no valid expected one");
    end else begin
      v = valid_q[rd_v]; rd_v++;
      vectors++; if (v.ch != 0 || v.data != (1 << DATA_W) - 1) begin
        miscompares++; $display("FAIL endrop_data: got ch%0d=%0h expected ch0=%0h", v.ch, v.data, (1 << DATA_W) - 1);
      end
    end
    v0 = valid_q.size();
`endif
    n0 = n_falls;
    repeat (400) @(negedge clk);
    #1;
    vectors++; if (n_falls != n0) begin miscompares++; $display("FAIL endrop_restart: got %0d new frames expected 0", n_falls - n0); end
    vectors++; if (ncs !== 1'b1 || busy !== 1'b0 || valid_q.size() != v0) begin
      miscompares++; $display("FAIL endrop_idle: got ncs=%b busy=%b expected 1,0", ncs, busy);
    end
    din_one = 1'b0;
  endtask

`ifdef SPI_ADC_OVERSAMPLE_EN
  task automatic test_oversample();
    bit ok;
    int s, exp_val;
    valid_t v;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      s = 0;
      for (int i = 0; i < 4; i++) begin
        int x;
        x = (r == 0) ? 100 + i : $urandom_range(0, (1 << DATA_W) - 1);
        os_vals.push_back(x);
        s += x;
      end
      exp_val = s / 4;
      ch_mask = 2'b01; en = 1'b1;
      wait_valid(ok);
      en = 1'b0;
      vectors++;
      if (!ok) begin
        miscompares++; $display("FAIL os_timeout[%0d]: got no valid expected one", r);
      end else begin
        v = valid_q[rd_v]; rd_v++;
        vectors++; if (v.data != exp_val || v.ch != 0) begin
          miscompares++; $display("FAIL os_avg[%0d]: got ch%0d=%0d expected ch0=%0d", r, v.ch, v.data, exp_val);
        end
      end
      os_rd = os_vals.size();
    end
  endtask
`endif

  initial begin
    reset = 1'b1; en = 1'b0; ch_mask = '0; din_one = 1'b0;
    for (int c = 0; c < NUM_CH; c++) adc_val[c] = 0;
    test_reset();
    adc_val[0] = 'h2A5; adc_val[1] = 'h155;
    test_scan("single_ch", 1, 3, 1'b0);
    adc_val[0] = 'h100; adc_val[1] = 'h0FF;
    test_scan("round_robin", 3, 4, 1'b0);
    for (int c = 0; c < NUM_CH; c++) adc_val[c] = $urandom_range(0, (1 << DATA_W) - 1);
    test_scan("random_mask", $urandom_range(1, (1 << NUM_CH) - 1), 8, 1'b1);
    test_mask_zero();
    test_reset_mid_frame();
    test_en_drop();
`ifdef SPI_ADC_OVERSAMPLE_EN
    test_oversample();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
